hs_width_packer: RTL and testbench
==================================

HS_WIDTH_PACKER -- requirements
Module: hs_width_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, the width of one upstream word.
REQ-002 SHALL have parameter RATIO, default 4, the number of upstream words per downstream word; legal range 2..16.
REQ-003 SHALL have port clk, input, 1, the clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have port up_valid, input, 1, upstream word valid.
REQ-006 SHALL have port up_data, input, WORD_WIDTH, upstream word.
REQ-007 SHALL have port up_ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port down_valid, output, 1, packed word valid.
REQ-009 SHALL have port down_data, output, WORD_WIDTH*RATIO, packed word.
REQ-010 SHALL have port down_ready, input, 1, downstream accepts the packed word.

Function
REQ-011 SHALL treat upstream accept as up_valid && up_ready, and downstream transfer as down_valid && down_ready.
REQ-012 SHALL drive up_ready = !down_valid || down_ready (combinational); no combinational path from up_valid to up_ready.
REQ-013 SHALL keep a lane counter cnt of width clog2(RATIO), 0..RATIO-1; each upstream accept writes up_data into down_data[cnt*WORD_WIDTH +: WORD_WIDTH] and advances cnt.
REQ-014 SHALL clear lanes 1..RATIO-1 of down_data to 0 on the accept that writes lane 0.
REQ-015 SHALL wrap cnt from RATIO-1 to 0 and set down_valid on the next edge (latency: 1 cycle after the RATIO-th accept).
REQ-016 SHALL hold down_data and down_valid stable while down_valid && !down_ready.
REQ-017 SHALL clear down_valid on a downstream transfer unless the same edge completes a new word; in that case down_valid stays 1 and down_data carries the new word.
REQ-018 SHALL sustain one upstream accept per cycle when down_ready is held 1 (no bubble at word boundaries).
REQ-019 SHALL ignore up_data when no accept occurs; cnt and down_data remain unchanged.
REQ-020 SHALL never drop or duplicate a word; upstream order maps to ascending lane order, lane 0 = first accepted.

Reset
REQ-021 SHALL, while rst_n=0 at a rising edge, set down_valid=0, cnt=0, down_data=0; up_ready then reads 1.
REQ-022 SHALL discard any partially filled or unaccepted packed word on reset mid-operation; the first accept after reset goes to lane 0.

Configuration
REQ-023 SHALL, when macro HS_PACK_LAST_EN is defined, add ports up_last (input, 1) and down_keep (output, RATIO).
REQ-024 SHALL, with HS_PACK_LAST_EN, close the packed word on an accept with up_last=1 regardless of cnt, set down_keep bit k for each filled lane, leave unfilled lanes 0, and reset cnt to 0.
REQ-025 SHALL, with HS_PACK_LAST_EN, drive down_keep all-ones for full words and reset down_keep to 0.
REQ-026 SHALL, without HS_PACK_LAST_EN, have neither port, and close words only on a full count.

Structure
REQ-027 SHALL take default constants HS_DEF_WORD_WIDTH=8 and HS_DEF_RATIO=4 and the clog2 helper from shared package hs_pkg.
REQ-028 SHALL be a single module with no sub-module; the lane counter is inline.

Verification
REQ-029 SHALL cover: down_ready=1, up_valid=1, bytes 0x11,0x22,0x33,0x44,0x55 -> down_data=0x44332211, down_valid one cycle after the 4th accept, 0x55 in lane 0 of the next word, no bubble.
REQ-030 SHALL cover: down_ready=0 after 4 accepts of 0xA0..0xA3 -> down_valid=1 and up_ready=0 held; 0xA3A2A1A0 stable for 5 cycles; then down_ready=1 -> transfer and up_ready=1.
REQ-031 SHALL cover: down_valid=1 with down_ready=1 on the same edge as the 4th accept of the next word -> down_valid stays 1 and down_data updates with no lost word.
REQ-032 SHALL cover: 2 accepts (0x01,0x02), then rst_n=0 for 1 cycle, then 4 accepts 0x10..0x13 -> first output 0x13121110.
REQ-033 SHALL cover (HS_PACK_LAST_EN): accepts 0x07,0x08 with up_last=1 on 0x08 -> down_data=0x00000807, down_keep=4'b0011, next accept lands in lane 0.
REQ-034 SHALL cover: random up_valid/down_ready at 50 % over 1000 words -> scoreboard matches byte order exactly; down_data never changes while down_valid && !down_ready.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared constants and helpers for the hs_* handshake blocks.
package hs_pkg;

  localparam int HS_DEF_WORD_WIDTH = 32'sd8;
  localparam int HS_DEF_RATIO      = 32'sd4;

  // Bits needed to index value distinct items (value >= 2).
  function automatic int hs_clog2(input int value);
    int res;
    res = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hs_width_packer.sv
// Packs RATIO upstream words into one wide downstream word, lane 0 first.
// Optional HS_PACK_LAST_EN adds up_last/down_keep for early-closed short words.
module hs_width_packer
  import hs_pkg::*;
#(
  parameter int WORD_WIDTH = HS_DEF_WORD_WIDTH,
  parameter int RATIO      = HS_DEF_RATIO
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_valid,
  input  logic [WORD_WIDTH-1:0]         up_data,
`ifdef HS_PACK_LAST_EN
  input  logic                          up_last,
  output logic [RATIO-1:0]              down_keep,
`endif
  output logic                          up_ready,
  output logic                          down_valid,
  output logic [WORD_WIDTH*RATIO-1:0]   down_data,
  input  logic                          down_ready
);

  localparam int CNT_W = hs_clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic [WORD_WIDTH*RATIO-1:0] data_r;
  logic [WORD_WIDTH*RATIO-1:0] data_nxt_s;
  logic                        valid_r;
  logic                        accept_s;
  logic                        transfer_s;
  logic                        close_s;
  logic                        last_s;
`ifdef HS_PACK_LAST_EN
  logic [RATIO-1:0]            keep_r;
  logic [RATIO-1:0]            keep_nxt_s;
`endif

  assign up_ready   = !valid_r || down_ready;
  assign down_valid = valid_r;
  assign down_data  = data_r;
`ifdef HS_PACK_LAST_EN
  assign down_keep  = keep_r;
  assign last_s     = up_last;
`else
  assign last_s     = 1'b0;
`endif

  // Next lane contents and counter; a lane-0 write starts a fresh, zeroed word.
  always_comb begin
    accept_s   = up_valid && up_ready;
    transfer_s = valid_r && down_ready;
    close_s    = 1'b0;
    cnt_nxt_s  = cnt_r;
    data_nxt_s = data_r;
`ifdef HS_PACK_LAST_EN
    keep_nxt_s = keep_r;
`endif
    if (accept_s) begin
      if (cnt_r == '0) begin
        data_nxt_s = '0;
`ifdef HS_PACK_LAST_EN
        keep_nxt_s = '0;
`endif
      end else begin
        data_nxt_s = data_r;
      end
      data_nxt_s[cnt_r*WORD_WIDTH +: WORD_WIDTH] = up_data;
`ifdef HS_PACK_LAST_EN
      keep_nxt_s[cnt_r] = 1'b1;
`endif
      close_s = (cnt_r == LAST_LANE) || last_s;
      if (close_s) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      close_s = 1'b0;
    end
  end

  // State update; completing a word wins over clearing valid on a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      cnt_r   <= '0;
      data_r  <= '0;
`ifdef HS_PACK_LAST_EN
      keep_r  <= '0;
`endif
    end else begin
      cnt_r  <= cnt_nxt_s;
      data_r <= data_nxt_s;
`ifdef HS_PACK_LAST_EN
      keep_r <= keep_nxt_s;
`endif
      if (accept_s && close_s) begin
        valid_r <= 1'b1;
      end else if (transfer_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

endmodule

// File: tb/tb_hs_width_packer.sv
// Scoreboard bench for hs_width_packer (WORD_WIDTH=8, RATIO=4).
module tb_hs_width_packer;

  localparam int W = 8;
  localparam int R = 4;

  logic           clk;
  logic           rst_n;
  logic           up_valid;
  logic [W-1:0]   up_data;
  logic           up_ready;
  logic           down_valid;
  logic [W*R-1:0] down_data;
  logic           down_ready;
  logic           up_last;
  logic [R-1:0]   down_keep;

  int n_total;
  int n_bad;
  int words_in;

  // bench model state
  bit             m_valid;
  int             m_cnt;
  logic [W*R-1:0] m_word;
  logic [R-1:0]   m_keep;
  logic [W*R-1:0] exp_q[$];
  logic [R-1:0]   keep_q[$];

  hs_width_packer #(.WORD_WIDTH(W), .RATIO(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
`ifdef HS_PACK_LAST_EN
    .up_last    (up_last),
    .down_keep  (down_keep),
`endif
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_cnt   = 0;
    m_word  = '0;
    m_keep  = '0;
    exp_q.delete();
    keep_q.delete();
  endtask

  // One clock: check outputs against the model, step the edge, advance the model.
  task automatic tick();
    bit m_rdy;
    bit acc;
    bit xfer;
    bit done;
    #1;
    m_rdy = !m_valid || down_ready;
    acc   = up_valid && m_rdy;
    xfer  = m_valid && down_ready;
    done  = 1'b0;
    check_eq("up_ready", up_ready, m_rdy);
    check_eq("down_valid", down_valid, m_valid);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", exp_q.size(), 1);
      end else begin
        check_eq("down_data", down_data, exp_q[0]);
`ifdef HS_PACK_LAST_EN
        check_eq("down_keep", down_keep, keep_q[0]);
`endif
        if (xfer) begin
          void'(exp_q.pop_front());
          void'(keep_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (acc) begin
        if (m_cnt == 0) begin
          m_word = '0;
          m_keep = '0;
        end
        m_word[m_cnt*W +: W] = up_data;
        m_keep[m_cnt] = 1'b1;
        m_cnt++;
`ifdef HS_PACK_LAST_EN
        if (up_last) done = 1'b1;
`endif
        if (m_cnt == R) done = 1'b1;
        if (done) begin
          exp_q.push_back(m_word);
          keep_q.push_back(m_keep);
          m_cnt = 0;
          words_in++;
        end
      end
      if (acc && done) m_valid = 1'b1;
      else if (xfer) m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy, input bit last);
    up_valid   = v;
    up_data    = d;
    down_ready = rdy;
    up_last    = last;
    tick();
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (m_valid && c < 50) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      c++;
    end
    check_eq("drain_valid", m_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] bytes5[5];
    n_total  = 0;
    n_bad    = 0;
    words_in = 0;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    up_last    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", down_valid, 1'b0);
    check_eq("rst_data", down_data, 32'h0);
    check_eq("rst_ready", up_ready, 1'b1);
    rst_n = 1'b1;

    // streaming with down_ready held high: no bubble at the word boundary
    bytes5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) drive(1'b1, bytes5[i], 1'b1, 1'b0);
    check_eq("w1_valid", down_valid, 1'b1);
    check_eq("w1_data", down_data, 32'h44332211);
    drive(1'b1, bytes5[4], 1'b1, 1'b0);
    check_eq("w2_lane0", down_data[7:0], 8'h55);
    check_eq("w2_valid", down_valid, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h56 + 8'(i), 1'b1, 1'b0);
    drain();

    // backpressure: word held, upstream stalled
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hB0, 1'b0, 1'b0);
      check_eq("stall_data", down_data, 32'hA3A2A1A0);
      check_eq("stall_ready", up_ready, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("bp_released", down_valid, 1'b0);
    check_eq("bp_ready", up_ready, 1'b1);

    // reset in mid-word discards the partial word
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    check_eq("rst_first", down_data, 32'h13121110);
    drain();

`ifdef HS_PACK_LAST_EN
    // short word closed by up_last, then a one-lane word on the transfer edge
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    drive(1'b1, 8'h08, 1'b1, 1'b1);
    check_eq("last_data", down_data, 32'h00000807);
    check_eq("last_keep", down_keep, 4'b0011);
    drive(1'b1, 8'h09, 1'b1, 1'b1);
    check_eq("same_edge_valid", down_valid, 1'b1);
    check_eq("same_edge_data", down_data, 32'h00000009);
    drain();
`endif

    // random valid/ready traffic against the scoreboard
    words_in = 0;
    for (int c = 0; c < 40000 && words_in < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    check_eq("rand_words", (words_in >= 1000), 1'b1);
    drain();
    check_eq("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
